image_filter_stream: RTL
========================

# image_filter_stream

Parametrised streaming 3×3 image filter for raster-order grayscale pixels. It combines two-row line buffering, a 3×3 window and a selectable kernel datapath in one block, and adds frame and line tracking, a per-frame mode latch and start-of-frame resynchronisation. It sits between the pixel source (DMA/stream input) and the output stream sink, in the same position as the current fixed box-filter pipeline.

## Interface
- `DATA_W`, default 8: pixel width in bits; unsigned.
- `IMG_W`, default 512: pixels per line; must be ≥3.
- `IMG_H`, default 512: lines per frame; must be ≥3.
- `i_clk` input, 1 bit: single clock; all logic is rising-edge.
- `i_rst_n` input, 1 bit: reset, asynchronous and active-low.
- `i_mode` input, 2 bits: kernel select. 0 = bypass (window centre), 1 = Gaussian [1 2 1; 2 4 2; 1 2 1]/16, 2 = sharpen (5c − N − S − E − W), 3 = Sobel |Gx|+|Gy|.
- `i_data_valid` input, 1 bit: input pixel qualifier.
- `i_sof` input, 1 bit: start of frame; sampled only with `i_data_valid`.
- `i_data` input, `DATA_W` bits: input pixel.
- `o_data_valid` output, 1 bit: output pixel qualifier.
- `o_data` output, `DATA_W` bits: filtered pixel.
- `o_line_done` output, 1 bit: one-cycle pulse coincident with the last output pixel of an output row.
- `o_frame_done` output, 1 bit: one-cycle pulse coincident with the last output pixel of a frame.

## Operation
- **Accepted pixel:** every cycle with `i_data_valid`=1. There is no backpressure; gaps of any length are legal.
- **Position counters:** column `c` (0..IMG_W−1) and row `r` (0..IMG_H−1) advance on each accepted pixel. `c` wraps to 0 and increments `r`; after (IMG_H−1, IMG_W−1) both wrap to 0.
- **Resynchronisation:** `i_sof`=1 with a valid pixel forces that pixel to position (0,0), whatever the counter state.
- **Mode latch:** `i_mode` is latched when the pixel at (0,0) is accepted. A change mid-frame has no effect until the next frame.
- **Line buffers:** two rows of IMG_W × DATA_W, written and read at column `c`. The 3×3 window shift registers advance only on accepted pixels.
- **Output window rule:** an output is generated only for a full window, i.e. an accepted pixel with r≥2 and c≥2. That output is centred at (r−1, c−1). Each frame therefore yields (IMG_W−2)×(IMG_H−2) outputs; borders are dropped.
- **Window naming:** p[i][j], i = row (0 = oldest), j = column (0 = leftmost).
- **Arithmetic:** signed intermediates, DATA_W+5 bits wide.
  - Gaussian: weighted sum, then >>4 (truncate).
  - Sharpen: clamp the result to [0, 2^DATA_W−1].
  - Sobel: Gx = (p02+2p12+p22) − (p00+2p10+p20) and Gy = (p20+2p21+p22) − (p00+2p01+p02). The output is |Gx|+|Gy|, saturated to 2^DATA_W−1.
- **Line/frame flags:** `o_line_done` is asserted with the output of input column c = IMG_W−1. `o_frame_done` is asserted with the output of input position (IMG_H−1, IMG_W−1).
- **Frame boundaries:** line-buffer contents are not cleared between frames. Stale data can never reach the output because r<2 suppresses output.

## Timing
- **Latency:** a fixed 3 cycles from accepting the window-completing pixel to `o_data_valid`.
  - Stage 1: window register update.
  - Stage 2: partial sums / products.
  - Stage 3: final sum, abs, clamp and output register.
- **Pipeline behaviour:** the pipeline is free-running; valid bits shift every cycle regardless of input gaps. Back-to-back inputs give back-to-back outputs.
- **Output hold:** `o_data` holds its last value when `o_data_valid`=0.
- **Reset values:**
  - `o_data_valid`, `o_line_done`, `o_frame_done` = 0; `o_data` = 0.
  - Counters = (0,0); latched mode = 0; pipeline valids cleared.
  - Line-buffer RAM is not reset.
- **Reset mid-frame:** the frame is aborted, in-flight outputs are discarded, and the next accepted pixel is (0,0).
- **`i_sof` on a pixel already at (0,0):** no extra effect.
- **`i_sof` mid-frame:** the partial frame is abandoned and no `o_frame_done` is issued for it. Outputs already in the pipeline still emerge.

## Structure
- **Package `image_filter_pkg`:** mode constants (MODE_BYPASS/GAUSS/SHARPEN/SOBEL) and the intermediate-width localparam rule.
- **Sub-module `line_buffer_2row`:** parameters DATA_W and IMG_W. Provides two-row RAM, synchronous read at the write address, and a column-enable input.
- **Top module:** counters, mode latch, window registers, kernel pipeline and flag generation.

## Test plan
All scenarios use IMG_W=IMG_H=4 and DATA_W=8 unless stated otherwise.
- **Bypass:** mode 0, pixel = 4r+c, continuous valid → outputs 5, 6, 9, 10. `o_line_done` with 6 and 10; `o_frame_done` with 10; each output 3 cycles after its completing input.
- **Gaussian, constant input:** mode 1, all pixels 200 → four outputs of 200.
- **Sharpen, constant input:** mode 2, all pixels 100 → 100.
- **Sharpen clamp:** centre pixel (1,1)=255, all others 0 → output at (1,1) = 255. Centre 0, all others 255 → output at (1,1) = 0.
- **Sobel edge:** mode 3, column 0 = 0, columns 1–3 = 255 → outputs centred at column 1 = 255 (saturated from 1020); outputs centred at column 2 = 0.
- **Robustness:**
  - Random valid gaps → identical output values and counts.
  - `i_mode` changed mid-frame → ignored.
  - `i_sof` at pixel 7 → a new frame is counted from that pixel.
  - `i_rst_n` pulsed mid-frame → no outputs from the aborted frame after reset, and the next frame is correct.

Source files
------------

// File: rtl/image_filter_pkg.sv
// Shared definitions for the streaming 3x3 image filter: kernel modes and
// the rule for sizing the signed kernel intermediates.
package image_filter_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_GAUSS   = 2'd1,
        MODE_SHARPEN = 2'd2,
        MODE_SOBEL   = 2'd3
    } mode_e;

    localparam int unsigned ACC_EXTRA_W = 5;

    // Signed headroom for the widest kernel sum (Sobel |Gx|+|Gy| up to 8x pixel max)
    function automatic int unsigned acc_w(input int unsigned data_w);
        return data_w + ACC_EXTRA_W;
    endfunction

endpackage

// File: rtl/line_buffer_2row.sv
// Two-row pixel line buffer: read-before-write at the current column, with the
// two previous rows presented as registered outputs.
module line_buffer_2row #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 512
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [$clog2(IMG_W)-1:0] i_col,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_top,
    output logic [DATA_W-1:0]        o_mid
);
    // row0 holds the most recent full row, row1 the one before it
    logic [DATA_W-1:0] row0_mem [IMG_W];
    logic [DATA_W-1:0] row1_mem [IMG_W];

    logic [DATA_W-1:0] top_q, top_d;
    logic [DATA_W-1:0] mid_q, mid_d;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            row0_mem[i_col] <= i_wdata;
            row1_mem[i_col] <= row0_mem[i_col];
        end
    end

    always_comb begin
        top_d = top_q;
        mid_d = mid_q;
        if (i_en) begin
            top_d = row1_mem[i_col];
            mid_d = row0_mem[i_col];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            top_q <= '0;
            mid_q <= '0;
        end else begin
            top_q <= top_d;
            mid_q <= mid_d;
        end
    end

    assign o_top = top_q;
    assign o_mid = mid_q;

endmodule

// File: rtl/image_filter_stream.sv
// Streaming 3x3 image filter: raster position tracking, per-frame mode latch,
// two-row line buffering and a three-stage kernel pipeline.
module image_filter_stream
    import image_filter_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 512,
    parameter int unsigned IMG_H  = 512
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_mode,
    input  logic              i_data_valid,
    input  logic              i_sof,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_data_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_line_done,
    output logic              o_frame_done
);
    localparam int unsigned ACC_W = acc_w(DATA_W);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX = $signed({{(ACC_W - DATA_W){1'b0}}, {DATA_W{1'b1}}});

    function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_W-1:0] x);
        return $signed({{(ACC_W - DATA_W){1'b0}}, x});
    endfunction

    // Position counters and frame mode latch
    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;
    mode_e            mode_q, mode_d;

    always_comb begin
        col_cur = i_sof ? '0 : col_q;
        row_cur = i_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        mode_d  = mode_q;
        if (i_data_valid) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + ROW_W'(1);
            end else begin
                col_d = col_cur + COL_W'(1);
                row_d = row_cur;
            end
            if (col_cur == '0 && row_cur == '0) begin
                mode_d = mode_e'(i_mode);
            end
        end
    end

    logic [DATA_W-1:0] lb_top, lb_mid;

    line_buffer_2row #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_line_buffer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_data_valid),
        .i_col   (col_cur),
        .i_wdata (i_data),
        .o_top   (lb_top),
        .o_mid   (lb_mid)
    );

    // Stage 1: window columns; column 2 is the line-buffer read plus the held pixel
    logic [DATA_W-1:0]           pix_q, pix_d;
    logic [2:0][DATA_W-1:0]      col0_q, col0_d, col1_q, col1_d;
    logic [2:0][DATA_W-1:0]      col2;
    logic                        s1_vld_q, s1_vld_d, s1_line_q, s1_line_d, s1_frame_q, s1_frame_d;
    mode_e                       s1_mode_q, s1_mode_d;

    assign col2 = {pix_q, lb_mid, lb_top};

    always_comb begin
        pix_d      = pix_q;
        col0_d     = col0_q;
        col1_d     = col1_q;
        s1_vld_d   = 1'b0;
        s1_line_d  = 1'b0;
        s1_frame_d = 1'b0;
        s1_mode_d  = s1_mode_q;
        if (i_data_valid) begin
            pix_d      = i_data;
            col1_d     = col2;
            col0_d     = col1_q;
            s1_vld_d   = (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));
            s1_line_d  = s1_vld_d && (col_cur == COL_LAST);
            s1_frame_d = s1_line_d && (row_cur == ROW_LAST);
            s1_mode_d  = mode_q;
        end
    end

    logic signed [ACC_W-1:0] p [3][3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            p[i][0] = ext(col0_q[i]);
            p[i][1] = ext(col1_q[i]);
            p[i][2] = ext(col2[i]);
        end
    end

    // Stage 2: per-kernel partial terms (a, b) combined in stage 3
    logic                    s2_vld_q, s2_vld_d, s2_line_q, s2_line_d, s2_frame_q, s2_frame_d;
    mode_e                   s2_mode_q, s2_mode_d;
    logic signed [ACC_W-1:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d;

    always_comb begin
        s2_vld_d   = s1_vld_q;
        s2_line_d  = s1_line_q;
        s2_frame_d = s1_frame_q;
        s2_mode_d  = s2_mode_q;
        s2_a_d     = s2_a_q;
        s2_b_d     = s2_b_q;
        if (s1_vld_q) begin
            s2_mode_d = s1_mode_q;
            case (s1_mode_q)
                MODE_BYPASS: begin
                    s2_a_d = p[1][1];
                    s2_b_d = '0;
                end
                MODE_GAUSS: begin
                    s2_a_d = p[0][0] + p[0][2] + p[2][0] + p[2][2]
                           + ((p[0][1] + p[1][0] + p[1][2] + p[2][1]) <<< 1);
                    s2_b_d = p[1][1] <<< 2;
                end
                MODE_SHARPEN: begin
                    s2_a_d = (p[1][1] <<< 2) + p[1][1];
                    s2_b_d = p[0][1] + p[1][0] + p[1][2] + p[2][1];
                end
                MODE_SOBEL: begin
                    s2_a_d = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
                    s2_b_d = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
                end
            endcase
        end
    end

    // Stage 3: final combine, abs/clamp and output register
    logic                    o_vld_q, o_vld_d, o_line_q, o_line_d, o_frame_q, o_frame_d;
    logic [DATA_W-1:0]       o_data_q, o_data_d;
    logic signed [ACC_W-1:0] gauss_sum, sharp_val, abs_a, abs_b, sobel_val;

    always_comb begin
        gauss_sum = s2_a_q + s2_b_q;
        sharp_val = s2_a_q - s2_b_q;
        abs_a     = s2_a_q[ACC_W-1] ? -s2_a_q : s2_a_q;
        abs_b     = s2_b_q[ACC_W-1] ? -s2_b_q : s2_b_q;
        sobel_val = abs_a + abs_b;
        o_vld_d   = s2_vld_q;
        o_line_d  = s2_vld_q && s2_line_q;
        o_frame_d = s2_vld_q && s2_frame_q;
        o_data_d  = o_data_q;
        if (s2_vld_q) begin
            case (s2_mode_q)
                MODE_BYPASS:  o_data_d = DATA_W'(s2_a_q);
                MODE_GAUSS:   o_data_d = DATA_W'(gauss_sum >>> 4);
                MODE_SHARPEN: begin
                    if (sharp_val < 0) begin
                        o_data_d = '0;
                    end else if (sharp_val > PIX_MAX) begin
                        o_data_d = '1;
                    end else begin
                        o_data_d = DATA_W'(sharp_val);
                    end
                end
                MODE_SOBEL:   o_data_d = (sobel_val > PIX_MAX) ? '1 : DATA_W'(sobel_val);
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            mode_q     <= MODE_BYPASS;
            pix_q      <= '0;
            col0_q     <= '0;
            col1_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_line_q  <= 1'b0;
            s1_frame_q <= 1'b0;
            s1_mode_q  <= MODE_BYPASS;
            s2_vld_q   <= 1'b0;
            s2_line_q  <= 1'b0;
            s2_frame_q <= 1'b0;
            s2_mode_q  <= MODE_BYPASS;
            s2_a_q     <= '0;
            s2_b_q     <= '0;
            o_vld_q    <= 1'b0;
            o_line_q   <= 1'b0;
            o_frame_q  <= 1'b0;
            o_data_q   <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            mode_q     <= mode_d;
            pix_q      <= pix_d;
            col0_q     <= col0_d;
            col1_q     <= col1_d;
            s1_vld_q   <= s1_vld_d;
            s1_line_q  <= s1_line_d;
            s1_frame_q <= s1_frame_d;
            s1_mode_q  <= s1_mode_d;
            s2_vld_q   <= s2_vld_d;
            s2_line_q  <= s2_line_d;
            s2_frame_q <= s2_frame_d;
            s2_mode_q  <= s2_mode_d;
            s2_a_q     <= s2_a_d;
            s2_b_q     <= s2_b_d;
            o_vld_q    <= o_vld_d;
            o_line_q   <= o_line_d;
            o_frame_q  <= o_frame_d;
            o_data_q   <= o_data_d;
        end
    end

    assign o_data_valid = o_vld_q;
    assign o_data       = o_data_q;
    assign o_line_done  = o_line_q;
    assign o_frame_done = o_frame_q;

endmodule
